// File: rtl/pipeline_hazard_controller.sv
// Hazard/forwarding controller for a 5-stage pipeline: ALU forward selects,
// load-use and branch-operand stalls, data-memory wait freeze, PC redirects.
module pipeline_hazard_controller #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_branch,
   input  logic             id_jump,
   input  logic             id_jr,
   input  logic             branch_taken,
   input  logic [4:0]       ex_rs,
   input  logic [4:0]       ex_rt,
   input  logic [4:0]       idex_dest,
   input  logic             idex_regwrite,
   input  logic             idex_memread,
   input  logic [4:0]       exmem_dest,
   input  logic             exmem_regwrite,
   input  logic             exmem_memread,
   input  logic             exmem_memwrite,
   input  logic [4:0]       memwb_dest,
   input  logic             memwb_regwrite,
   input  logic             dmem_ready,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             stall_sel,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             branch_gate,
   output logic             jump_sel,
   output logic             jr_sel,
   output logic             freeze,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      STALL    = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   state_t     state, state_nxt;
   logic [1:0] rem, rem_nxt;
   logic [7:0] wait_cnt;

   logic       lu_haz, br1_haz, br2_haz, ctrl_op, mw_haz, freeze_cond;
   logic [1:0] haz_len;

   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic       em_wr, input logic [4:0] em_dest,
      input logic       mw_wr, input logic [4:0] mw_dest
   );
      if (em_wr && em_dest != 5'd0 && em_dest == src)
         return 2'd1;
      else if (mw_wr && mw_dest != 5'd0 && mw_dest == src)
         return 2'd2;
      else
         return 2'd0;
   endfunction

   // jr reads only rs; a branch compares rs and rt.
   function automatic logic op_match(
      input logic [4:0] dest, input logic [4:0] rs,
      input logic [4:0] rt,   input logic       uses_rt
   );
      return (dest != 5'd0) && (dest == rs || (uses_rt && dest == rt));
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (&v) ? v : v + 8'd1;
   endfunction

   always_comb begin
      ctrl_op = id_branch || id_jr;
      lu_haz  = idex_memread && idex_dest != 5'd0 &&
                (idex_dest == id_rs || idex_dest == id_rt);
      br2_haz = ctrl_op && idex_memread &&
                op_match(idex_dest, id_rs, id_rt, id_branch);
      br1_haz = ctrl_op &&
                ((idex_regwrite && !idex_memread &&
                  op_match(idex_dest, id_rs, id_rt, id_branch)) ||
                 (exmem_memread && op_match(exmem_dest, id_rs, id_rt, id_branch)));
      mw_haz  = (exmem_memread || exmem_memwrite) && !dmem_ready;
      if (br2_haz)
         haz_len = 2'd2;
      else if (lu_haz || br1_haz)
         haz_len = 2'd1;
      else
         haz_len = 2'd0;
      // Once waiting, only dmem_ready ends the freeze.
      freeze_cond = (state == MEM_WAIT) ? !dmem_ready : mw_haz;
   end

   always_comb begin
      state_nxt   = state;
      rem_nxt     = rem;
      fwd_a       = fwd_sel(ex_rs, exmem_regwrite, exmem_dest, memwb_regwrite, memwb_dest);
      fwd_b       = fwd_sel(ex_rt, exmem_regwrite, exmem_dest, memwb_regwrite, memwb_dest);
      stall_sel   = 1'b0;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      branch_gate = 1'b0;
      jump_sel    = 1'b0;
      jr_sel      = 1'b0;
      freeze      = 1'b0;

      if (reset) begin
         state_nxt  = RUN;
         rem_nxt    = 2'd0;
         fwd_a      = 2'd0;
         fwd_b      = 2'd0;
         stall_sel  = 1'b1;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b1;
      end else if (freeze_cond) begin
         freeze     = 1'b1;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         state_nxt  = MEM_WAIT;
      end else if (state != RUN && rem != 2'd0) begin
         // Remaining cycles of a multi-cycle stall, also resumed after a wait.
         stall_sel  = 1'b1;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         rem_nxt    = rem - 2'd1;
         state_nxt  = (rem == 2'd1) ? RUN : STALL;
      end else if (haz_len != 2'd0) begin
         stall_sel  = 1'b1;
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         rem_nxt    = haz_len - 2'd1;
         state_nxt  = (haz_len > 2'd1) ? STALL : RUN;
      end else begin
         state_nxt = RUN;
         if (id_jr)
            jr_sel = 1'b1;
         else if (id_jump)
            jump_sel = 1'b1;
         else if (id_branch && branch_taken)
            branch_gate = 1'b1;
         ifid_flush = jr_sel || jump_sel || branch_gate;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         rem       <= 2'd0;
         wait_cnt  <= 8'd0;
         mem_error <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state    <= state_nxt;
         rem      <= rem_nxt;
         wait_cnt <= freeze ? sat_inc8(wait_cnt) : 8'd0;
         if (freeze && wait_cnt >= TIMEOUT)
            mem_error <= 1'b1;
         if (stall_sel || freeze)
            stall_cnt <= sat_inc(stall_cnt);
         if (ifid_flush)
            flush_cnt <= sat_inc(flush_cnt);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: hand-computed expectations
// checked with immediate assertions.
module tb_pipeline_hazard_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, idex_dest, exmem_dest, memwb_dest;
   logic        id_branch, id_jump, id_jr, branch_taken;
   logic        idex_regwrite, idex_memread;
   logic        exmem_regwrite, exmem_memread, exmem_memwrite;
   logic        memwb_regwrite, dmem_ready;
   logic [1:0]  fwd_a, fwd_b;
   logic        stall_sel, pc_write, ifid_write, ifid_flush;
   logic        branch_gate, jump_sel, jr_sel, freeze, mem_error;
   logic [31:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   pipeline_hazard_controller #(.MEM_TIMEOUT(255), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_branch(id_branch), .id_jump(id_jump),
      .id_jr(id_jr), .branch_taken(branch_taken),
      .ex_rs(ex_rs), .ex_rt(ex_rt),
      .idex_dest(idex_dest), .idex_regwrite(idex_regwrite), .idex_memread(idex_memread),
      .exmem_dest(exmem_dest), .exmem_regwrite(exmem_regwrite),
      .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
      .memwb_dest(memwb_dest), .memwb_regwrite(memwb_regwrite),
      .dmem_ready(dmem_ready),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_sel(stall_sel), .pc_write(pc_write),
      .ifid_write(ifid_write), .ifid_flush(ifid_flush), .branch_gate(branch_gate),
      .jump_sel(jump_sel), .jr_sel(jr_sel), .freeze(freeze), .mem_error(mem_error),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      id_rs = 0; id_rt = 0; id_branch = 0; id_jump = 0; id_jr = 0; branch_taken = 0;
      ex_rs = 0; ex_rt = 0; idex_dest = 0; idex_regwrite = 0; idex_memread = 0;
      exmem_dest = 0; exmem_regwrite = 0; exmem_memread = 0; exmem_memwrite = 0;
      memwb_dest = 0; memwb_regwrite = 0; dmem_ready = 1;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_stall_out(input string tag);
      chk({tag, "_stall_sel"}, stall_sel, 1);
      chk({tag, "_pc_write"}, pc_write, 0);
      chk({tag, "_ifid_write"}, ifid_write, 0);
      chk({tag, "_flush"}, ifid_flush, 0);
   endtask

   task automatic chk_reset_out(input string tag);
      chk({tag, "_pc_write"}, pc_write, 0);
      chk({tag, "_ifid_write"}, ifid_write, 0);
      chk({tag, "_flush"}, ifid_flush, 1);
      chk({tag, "_stall_sel"}, stall_sel, 1);
      chk({tag, "_freeze"}, freeze, 0);
      chk({tag, "_selects"}, {branch_gate, jump_sel, jr_sel}, 0);
   endtask

   initial begin
      // Reset state
      reset = 1; idle();
      #2 chk_reset_out("rst_pre");
      adv();
      chk_reset_out("rst_held");
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
      chk("rst_mem_error", mem_error, 0);
      reset = 0; #1;
      chk("idle_pc_write", pc_write, 1);
      chk("idle_ifid_write", ifid_write, 1);
      chk("idle_stall_sel", stall_sel, 0);
      chk("idle_flush", ifid_flush, 0);

      // Forwarding priority and register 0
      ex_rs = 5; exmem_dest = 5; exmem_regwrite = 1; memwb_dest = 5; memwb_regwrite = 1;
      #1 chk("fwd_a_prio", fwd_a, 1);
      exmem_regwrite = 0;
      #1 chk("fwd_a_memwb", fwd_a, 2);
      ex_rs = 0; exmem_dest = 0; exmem_regwrite = 1; memwb_dest = 0;
      #1 chk("fwd_a_r0", fwd_a, 0);
      exmem_regwrite = 0; ex_rt = 7; memwb_dest = 7;
      #1 chk("fwd_b_memwb", fwd_b, 2);

      // Load-use on $t0
      adv(); idle();
      idex_memread = 1; idex_dest = 8; id_rs = 8; idex_regwrite = 1;
      #1 chk_stall_out("lu");
      adv(); idle();
      ex_rs = 8; memwb_dest = 8; memwb_regwrite = 1;
      #1 chk("lu_fwd_a", fwd_a, 2);
      chk("lu_resume_pc", pc_write, 1);
      chk("lu_stall_cnt", stall_cnt, 1);

      // Register 0 never creates a load-use hazard
      idle(); idex_memread = 1; idex_dest = 0; id_rs = 0;
      #1 chk("lu_r0_stall", stall_sel, 0);

      // Load then beq on $9: two stalls, then branch
      adv(); idle();
      id_branch = 1; branch_taken = 1; id_rs = 9; idex_memread = 1; idex_regwrite = 1; idex_dest = 9;
      #1 chk_stall_out("br2_c1");
      chk("br2_c1_gate", branch_gate, 0);
      adv();
      idex_memread = 0; idex_regwrite = 0; idex_dest = 0;
      exmem_memread = 1; exmem_dest = 9; exmem_regwrite = 1;
      #1 chk_stall_out("br2_c2");
      chk("br2_c2_gate", branch_gate, 0);
      adv();
      exmem_memread = 0; exmem_dest = 0; exmem_regwrite = 0;
      #1 chk("br2_gate", branch_gate, 1);
      chk("br2_flush", ifid_flush, 1);
      chk("br2_pc_write", pc_write, 1);
      chk("br2_stall_cnt", stall_cnt, 3);
      adv(); idle();
      #1 chk("br2_gate_once", branch_gate, 0);
      chk("br2_flush_cnt", flush_cnt, 1);

      // Branch not taken: no redirect
      id_branch = 1; id_rs = 3;
      #1 chk("bnt_gate", branch_gate, 0);
      chk("bnt_flush", ifid_flush, 0);

      // Redirect priority jr > jump, then jump alone
      idle(); id_jr = 1; id_jump = 1;
      #1 chk("jr_sel", jr_sel, 1);
      chk("jr_jump_sel", jump_sel, 0);
      chk("jr_flush", ifid_flush, 1);
      adv(); idle();
      #1 chk("jr_flush_cnt", flush_cnt, 2);
      id_jump = 1;
      #1 chk("jump_sel", jump_sel, 1);
      adv(); idle();
      #1 chk("jump_flush_cnt", flush_cnt, 3);

      // Memory wait of three cycles
      exmem_memread = 1; dmem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("mw_freeze", freeze, 1);
         chk("mw_pc_write", pc_write, 0);
         chk("mw_stall_sel", stall_sel, 0);
         adv();
      end
      dmem_ready = 1;
      #1 chk("mw_exit_freeze", freeze, 0);
      chk("mw_exit_pc_write", pc_write, 1);
      chk("mw_stall_cnt", stall_cnt, 6);
      chk("mw_no_error", mem_error, 0);

      // Timeout: error appears after the 256th waiting cycle and sticks
      adv(); idle(); exmem_memread = 1; dmem_ready = 0;
      repeat (255) adv();
      chk("to_255_error", mem_error, 0);
      adv();
      chk("to_256_error", mem_error, 1);
      chk("to_still_freeze", freeze, 1);
      idle();
      adv(); adv();
      chk("to_sticky", mem_error, 1);
      chk("to_freeze_off", freeze, 0);
      chk("to_stall_cnt", stall_cnt, 262);

      // Memory wait pre-empting a stall, remaining stall resumes afterwards
      idle(); id_branch = 1; id_rs = 9; idex_memread = 1; idex_dest = 9;
      #1 chk_stall_out("pre_c1");
      adv(); idle();
      id_branch = 1; exmem_memwrite = 1; dmem_ready = 0;
      #1 chk("pre_freeze", freeze, 1);
      chk("pre_freeze_stall_sel", stall_sel, 0);
      adv();
      dmem_ready = 1;
      #1 chk_stall_out("pre_resume");
      adv(); idle();
      #1 chk("pre_run_pc", pc_write, 1);
      chk("pre_stall_cnt", stall_cnt, 265);

      // Reset in STALL with rem = 1
      id_branch = 1; id_rs = 9; idex_memread = 1; idex_dest = 9;
      adv();
      reset = 1;
      #1 chk_reset_out("rst_stall");
      adv();
      chk_reset_out("rst_stall_held");
      chk("rst_stall_cnt2", stall_cnt, 0);
      chk("rst_flush_cnt2", flush_cnt, 0);
      chk("rst_mem_error2", mem_error, 0);
      reset = 0; idle();
      #1 chk("rst_run_pc", pc_write, 1);
      chk("rst_run_stall_sel", stall_sel, 0);
      adv();
      chk("rst_run_stall_cnt", stall_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
